// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-register busy scoreboard.
// Reads are combinational; writes and busy updates take effect at the rising clock edge.
module regfile_sb #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 5,
  parameter int unsigned READ_PORTS  = 2,
  parameter bit          BYPASS      = 1'b1,
  parameter bit          ZERO_REG    = 1'b1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_we,
  input  logic [INDEX_WIDTH-1:0]            i_waddr,
  input  logic [DATA_WIDTH-1:0]             i_wdata,
  input  logic                              i_issue,
  input  logic [INDEX_WIDTH-1:0]            i_issue_addr,
  input  logic [READ_PORTS*INDEX_WIDTH-1:0] i_raddr,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  o_rdata,
  output logic [READ_PORTS-1:0]             o_rbusy,
  output logic                              o_any_busy
);
  localparam int unsigned Depth = 2 ** INDEX_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic [Depth-1:0]      busy_q, busy_d;
  logic                  wr_en;
  logic                  issue_en;

  assign wr_en    = i_we && !(ZERO_REG && (i_waddr == '0));
  assign issue_en = i_issue && !(ZERO_REG && (i_issue_addr == '0));

  // Issue is applied last so it wins over a write to the same index.
  always_comb begin
    busy_d = busy_q;
    if (i_we) begin
      busy_d[i_waddr] = 1'b0;
    end
    if (issue_en) begin
      busy_d[i_issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned n = 0; n < Depth; n++) begin
        regs_q[n] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[i_waddr] <= i_wdata;
      end
      busy_q <= busy_d;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [INDEX_WIDTH-1:0] ra;
    logic                   is_zero;
    logic                   fwd;
    logic [DATA_WIDTH-1:0]  rd;
    logic                   rb;

    assign ra      = i_raddr[p*INDEX_WIDTH +: INDEX_WIDTH];
    assign is_zero = ZERO_REG && (ra == '0);
    assign fwd     = BYPASS && wr_en && (i_waddr == ra);

    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (i_rst || is_zero) begin
        rd = '0;
        rb = 1'b0;
      end else if (fwd) begin
        // Forwarded data resolves the hazard, so the port is not stalled.
        rd = i_wdata;
        rb = 1'b0;
      end else begin
        rd = regs_q[ra];
        rb = busy_q[ra];
      end
    end

    assign o_rdata[p*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign o_rbusy[p]                          = rb;
  end

  assign o_any_busy = !i_rst && (|busy_q);

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against an array-based reference model.
// A second instance built without bypass shares all inputs.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int RP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [IW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          issue;
  logic [IW-1:0] iaddr;
  logic [IW-1:0] raddr [RP];
  logic [RP*IW-1:0] raddr_vec;
  logic [RP*DW-1:0] rdata_a, rdata_b;
  logic [RP-1:0]    rbusy_a, rbusy_b;
  logic             any_a, any_b;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mregs [32];
  bit            mbusy [32];

  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < RP; p++) raddr_vec[p*IW +: IW] = raddr[p];
  end

  regfile_sb #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .READ_PORTS(RP), .BYPASS(1'b1),
               .ZERO_REG(1'b1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_issue(issue), .i_issue_addr(iaddr), .i_raddr(raddr_vec),
    .o_rdata(rdata_a), .o_rbusy(rbusy_a), .o_any_busy(any_a));

  regfile_sb #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .READ_PORTS(RP), .BYPASS(1'b0),
               .ZERO_REG(1'b1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_issue(issue), .i_issue_addr(iaddr), .i_raddr(raddr_vec),
    .o_rdata(rdata_b), .o_rbusy(rbusy_b), .o_any_busy(any_b));

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int n = 0; n < 32; n++) begin
      mregs[n] = '0;
      mbusy[n] = 1'b0;
    end
  endtask

  // Register 0 is constant zero and can never become pending.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      if (we && waddr != 0) mregs[waddr] = wdata;
      if (we) mbusy[waddr] = 1'b0;
      if (issue && iaddr != 0) mbusy[iaddr] = 1'b1;
    end
  endtask

  function automatic logic [DW-1:0] exp_rd_bypass(int p);
    if (rst || raddr[p] == 0) return '0;
    if (we && waddr == raddr[p]) return wdata;
    return mregs[raddr[p]];
  endfunction

  function automatic logic exp_rb_bypass(int p);
    if (rst || raddr[p] == 0) return 1'b0;
    if (we && waddr == raddr[p]) return 1'b0;
    return mbusy[raddr[p]];
  endfunction

  function automatic logic [DW-1:0] exp_rd_plain(int p);
    if (rst || raddr[p] == 0) return '0;
    return mregs[raddr[p]];
  endfunction

  function automatic logic exp_rb_plain(int p);
    if (rst || raddr[p] == 0) return 1'b0;
    return mbusy[raddr[p]];
  endfunction

  function automatic logic exp_any();
    logic r = 1'b0;
    if (rst) return 1'b0;
    for (int n = 0; n < 32; n++) r = r | mbusy[n];
    return r;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; waddr = '0; wdata = '0; issue = 0; iaddr = '0;
    for (int p = 0; p < RP; p++) raddr[p] = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    for (int p = 0; p < RP; p++) raddr[p] = IW'(p + 1);
    #2;
    vectors++;
    if (rdata_a !== '0 || rbusy_a !== '0 || any_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdata=%h rbusy=%b any=%b required all zero",
               rdata_a, rbusy_a, any_a);
    end
    @(posedge clk); #1;
    rst = 0;
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; issue = 1; iaddr = 2;
    tick();
    we = 1; waddr = 6; wdata = 32'h1111_1111; issue = 0;
    raddr[0] = 5; raddr[1] = 6;
    #2;
    vectors++;
    if (rdata_a[0 +: DW] !== 32'hDEADBEEF || any_a !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre: got x5=%h any=%b required deadbeef 1", rdata_a[0 +: DW], any_a);
    end
    rst = 1;
    model_reset();
    #1;
    vectors++;
    if (rdata_a[0 +: DW] !== '0 || rdata_a[DW +: DW] !== '0 || any_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got x5=%h x6=%h any=%b required 0 0 0",
               rdata_a[0 +: DW], rdata_a[DW +: DW], any_a);
    end
    @(posedge clk); #1;
    rst = 0; we = 0;
    #2;
    vectors++;
    if (rdata_a[DW +: DW] !== '0 || rdata_b[0 +: DW] !== '0) begin
      miscompares++;
      $display("FAIL reset_discard: got x6=%h x5=%h required 0 0",
               rdata_a[DW +: DW], rdata_b[0 +: DW]);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    we = 1; waddr = 0; wdata = 32'h1234; issue = 1; iaddr = 0;
    #2;
    vectors++;
    if (rdata_a !== '0 || rbusy_a !== '0) begin
      miscompares++;
      $display("FAIL zero_same: got rdata=%h rbusy=%b required 0", rdata_a, rbusy_a);
    end
    tick();
    idle_inputs();
    #2;
    vectors++;
    if (rdata_a !== '0 || rbusy_a !== '0 || any_a !== 1'b0 || rdata_b !== '0) begin
      miscompares++;
      $display("FAIL zero_next: got rdata=%h rbusy=%b any=%b required 0",
               rdata_a, rbusy_a, any_a);
    end
    tick();
  endtask

  task automatic test_bypass();
    idle_inputs();
    we = 1; waddr = 7; wdata = 32'hA5A5A5A5; raddr[1] = 7;
    #2;
    vectors++;
    if (rdata_a[DW +: DW] !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL bypass_on: got %h required a5a5a5a5", rdata_a[DW +: DW]);
    end
    vectors++;
    if (rdata_b[DW +: DW] !== 32'h0) begin
      miscompares++;
      $display("FAIL bypass_off: got %h required 00000000", rdata_b[DW +: DW]);
    end
    tick();
    we = 0;
    #2;
    vectors++;
    if (rdata_a[DW +: DW] !== 32'hA5A5A5A5 || rdata_b[DW +: DW] !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL bypass_next: got a=%h b=%h required a5a5a5a5",
               rdata_a[DW +: DW], rdata_b[DW +: DW]);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    issue = 1; iaddr = 3; raddr[0] = 3;
    #2;
    vectors++;
    if (rbusy_a[0] !== 1'b0 || any_a !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_issue_same: got rbusy=%b any=%b required 0 0", rbusy_a[0], any_a);
    end
    tick();
    issue = 0;
    #2;
    vectors++;
    if (rbusy_a[0] !== 1'b1 || any_a !== 1'b1 || rbusy_b[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_busy: got rbusy=%b any=%b required 1 1", rbusy_a[0], any_a);
    end
    we = 1; waddr = 3; wdata = 32'h55;
    #1;
    vectors++;
    if (rbusy_a[0] !== 1'b0 || rdata_a[0 +: DW] !== 32'h55 || rbusy_b[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_write_same: got rbusy=%b data=%h nobyp_busy=%b required 0 55 1",
               rbusy_a[0], rdata_a[0 +: DW], rbusy_b[0]);
    end
    tick();
    we = 0;
    #2;
    vectors++;
    if (rbusy_a[0] !== 1'b0 || any_a !== 1'b0 || rdata_b[0 +: DW] !== 32'h55) begin
      miscompares++;
      $display("FAIL sb_cleared: got rbusy=%b any=%b data=%h required 0 0 55",
               rbusy_a[0], any_a, rdata_b[0 +: DW]);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    issue = 1; iaddr = 9; we = 1; waddr = 9; wdata = 32'h77;
    tick();
    idle_inputs();
    raddr[2] = 9;
    #2;
    vectors++;
    if (rdata_a[2*DW +: DW] !== 32'h77 || rbusy_a[2] !== 1'b1 || any_a !== 1'b1) begin
      miscompares++;
      $display("FAIL simultaneous: got data=%h rbusy=%b any=%b required 77 1 1",
               rdata_a[2*DW +: DW], rbusy_a[2], any_a);
    end
    tick();
  endtask

  task automatic test_random(int cycles);
    int bad = 0;
    for (int c = 0; c < cycles; c++) begin
      we    = ($urandom_range(0, 99) < 60);
      waddr = IW'($urandom_range(0, 31));
      wdata = $urandom;
      issue = ($urandom_range(0, 99) < 40);
      iaddr = IW'($urandom_range(0, 31));
      for (int p = 0; p < RP; p++) begin
        case ($urandom_range(0, 3))
          0:       raddr[p] = waddr;
          1:       raddr[p] = raddr[0];
          default: raddr[p] = IW'($urandom_range(0, 31));
        endcase
      end
      #2;
      for (int p = 0; p < RP; p++) begin
        vectors++;
        if (rdata_a[p*DW +: DW] !== exp_rd_bypass(p) || rbusy_a[p] !== exp_rb_bypass(p)) begin
          miscompares++;
          if (bad++ < 10)
            $display("FAIL rand_byp c=%0d p=%0d x%0d: got %h/%b required %h/%b", c, p,
                     raddr[p], rdata_a[p*DW +: DW], rbusy_a[p], exp_rd_bypass(p),
                     exp_rb_bypass(p));
        end
        vectors++;
        if (rdata_b[p*DW +: DW] !== exp_rd_plain(p) || rbusy_b[p] !== exp_rb_plain(p)) begin
          miscompares++;
          if (bad++ < 10)
            $display("FAIL rand_plain c=%0d p=%0d x%0d: got %h/%b required %h/%b", c, p,
                     raddr[p], rdata_b[p*DW +: DW], rbusy_b[p], exp_rd_plain(p),
                     exp_rb_plain(p));
        end
      end
      vectors++;
      if (any_a !== exp_any() || any_b !== exp_any()) begin
        miscompares++;
        if (bad++ < 10)
          $display("FAIL rand_any c=%0d: got %b/%b required %b", c, any_a, any_b, exp_any());
      end
      tick();
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_random(10000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
